// File: rtl/prbs31_lock_monitor_if.sv
// prbs31_lock_monitor_if: received word, clear strobe and lock/error statistics of the PRBS31 monitor.
interface prbs31_lock_monitor_if;
    logic [31:0] data_in;
    logic        clear;
    logic        locked;
    logic [1:0]  state;
    logic [31:0] err_mask;
    logic [5:0]  err_bits;
    logic [47:0] word_cnt;
    logic [47:0] bit_err_cnt;
    logic [31:0] word_err_cnt;
    logic [15:0] lock_loss_cnt;
    modport master (
        output data_in, clear,
        input  locked, state, err_mask, err_bits, word_cnt, bit_err_cnt, word_err_cnt, lock_loss_cnt
    );
    modport slave (
        input  data_in, clear,
        output locked, state, err_mask, err_bits, word_cnt, bit_err_cnt, word_err_cnt, lock_loss_cnt
    );
endinterface

// File: rtl/prbs31_lock_monitor.sv
// prbs31_lock_monitor: hunts for lock on a 32-bit PRBS31 stream, then checks words against a free-running predictor.
module prbs31_lock_monitor #(
    parameter int LOCK_CNT   = 64,
    parameter int UNLOCK_ERR = 16,
    parameter int WINDOW     = 256
) (
    input logic clk,
    input logic reset,
    prbs31_lock_monitor_if.slave bus
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(WINDOW + 1);
    localparam int EW = $clog2(UNLOCK_ERR + 1);
    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic [EW-1:0] ERR_LIM   = EW'(UNLOCK_ERR);
    typedef enum logic [1:0] {HUNT = 2'b00, VERIFY = 2'b01, LOCKED = 2'b10} state_t;
    // Upper half is filled serially so bits 28..31 reuse freshly computed bits 0..3.
    function automatic logic [31:0] pred(input logic [31:0] w);
        logic [63:0] s;
        s = {32'h0, w};
        for (int j = 0; j < 32; j++) s[32+j] = s[j+1] ^ s[j+4];
        return s[63:32];
    endfunction
    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
        return c;
    endfunction
    state_t state, state_nx;
    logic [31:0] prev, gen, expected, cur_mask, err_mask;
    logic [5:0] cur_bits, err_bits;
    logic prev_loaded, hit, cur_err, unlock, keep_win;
    logic [MW-1:0] match_cnt;
    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err, win_err_inc;
    logic [47:0] word_cnt, bit_err_cnt;
    logic [31:0] word_err_cnt;
    logic [15:0] lock_loss_cnt;
    logic [48:0] bit_sum;
    always_comb begin
        expected    = pred(gen);
        cur_mask    = bus.data_in ^ expected;
        cur_bits    = popcount(cur_mask);
        cur_err     = |cur_mask;
        hit         = bus.data_in == pred(prev) && bus.data_in != '0;
        win_err_inc = win_err + EW'(cur_err);
        unlock      = state == LOCKED && win_err_inc >= ERR_LIM;
        keep_win    = state == LOCKED && !unlock && win_cnt != WIN_LAST;
        bit_sum     = {1'b0, bit_err_cnt} + 49'(cur_bits);
    end
    always_ff @(posedge clk) begin
        state <= reset ? HUNT : state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            HUNT:    if (prev_loaded && hit) state_nx = (LOCK_CNT == 1) ? LOCKED : VERIFY;
            VERIFY:  state_nx = !hit ? HUNT : (match_cnt == LOCK_LAST) ? LOCKED : VERIFY;
            LOCKED:  if (unlock) state_nx = HUNT;
            default: state_nx = HUNT;
        endcase
    end
    always_comb begin
        bus.locked = state == LOCKED;
        bus.state  = state;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prev          <= '0;
            prev_loaded   <= 1'b0;
            gen           <= '0;
            match_cnt     <= '0;
            win_cnt       <= '0;
            win_err       <= '0;
            err_mask      <= '0;
            err_bits      <= '0;
            word_cnt      <= '0;
            bit_err_cnt   <= '0;
            word_err_cnt  <= '0;
            lock_loss_cnt <= '0;
        end else begin
            if (state != LOCKED) begin
                prev        <= bus.data_in;
                prev_loaded <= 1'b1;
            end
            match_cnt <= state_nx != VERIFY ? '0 : state == HUNT ? MW'(1) : match_cnt + MW'(1);
            gen       <= state == LOCKED ? expected : state_nx == LOCKED ? bus.data_in : gen;
            err_mask  <= state == LOCKED ? cur_mask : '0;
            err_bits  <= state == LOCKED ? cur_bits : '0;
            win_cnt   <= keep_win ? win_cnt + WW'(1) : '0;
            win_err   <= keep_win ? win_err_inc : '0;
            if (bus.clear) begin
                word_cnt      <= '0;
                bit_err_cnt   <= '0;
                word_err_cnt  <= '0;
                lock_loss_cnt <= '0;
            end else if (state == LOCKED) begin
                word_cnt    <= &word_cnt ? word_cnt : word_cnt + 48'd1;
                bit_err_cnt <= bit_sum[48] ? '1 : bit_sum[47:0];
                if (cur_err && !(&word_err_cnt)) word_err_cnt <= word_err_cnt + 32'd1;
                if (unlock && !(&lock_loss_cnt)) lock_loss_cnt <= lock_loss_cnt + 16'd1;
            end
        end
    end
    assign bus.err_mask      = err_mask;
    assign bus.err_bits      = err_bits;
    assign bus.word_cnt      = word_cnt;
    assign bus.bit_err_cnt   = bit_err_cnt;
    assign bus.word_err_cnt  = word_err_cnt;
    assign bus.lock_loss_cnt = lock_loss_cnt;
endmodule

// File: tb/tb_prbs31_lock_monitor.sv
// tb_prbs31_lock_monitor: directed PRBS31 stream with bit flips, checked against a serial reference generator.
module tb_prbs31_lock_monitor;
    localparam logic [1:0] H = 2'b00, V = 2'b01, L = 2'b10;
    typedef struct {
        logic [31:0] mask;
        logic [5:0]  bits;
        logic [1:0]  st;
        logic [47:0] wc;
        logic [47:0] bec;
        logic [31:0] wec;
        logic [15:0] llc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    logic [30:0] h = 31'h2A5A1234;
    logic [1:0] cur_st = H;
    logic [47:0] m_wc = '0, m_bec = '0;
    logic [31:0] m_wec = '0;
    logic [15:0] m_llc = '0;
    prbs31_lock_monitor_if bus ();
    prbs31_lock_monitor dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask
    // Serial reference: h[k] holds s[n-31+k], so each new bit is h[0] ^ h[3].
    task automatic prbs_word(output logic [31:0] w);
        logic b;
        w = '0;
        for (int i = 0; i < 32; i++) begin
            b = h[0] ^ h[3];
            w[i] = b;
            h = {b, h[30:1]};
        end
    endtask
    task automatic check_outputs(input exp_t e);
        chk("state", 64'(bus.state), 64'(e.st));
        chk("locked", 64'(bus.locked), 64'(e.st == L));
        chk("err_mask", 64'(bus.err_mask), 64'(e.mask));
        chk("err_bits", 64'(bus.err_bits), 64'(e.bits));
        chk("word_cnt", 64'(bus.word_cnt), 64'(e.wc));
        chk("bit_err_cnt", 64'(bus.bit_err_cnt), 64'(e.bec));
        chk("word_err_cnt", 64'(bus.word_err_cnt), 64'(e.wec));
        chk("lock_loss_cnt", 64'(bus.lock_loss_cnt), 64'(e.llc));
    endtask
    task automatic send(input logic [31:0] flip, input logic zero, input logic clr, input logic [1:0] st);
        exp_t e;
        logic [31:0] w;
        w = 32'h0;
        if (!zero) prbs_word(w);
        bus.data_in = w ^ flip;
        bus.clear = clr;
        e.mask = cur_st == L ? flip : 32'h0;
        e.bits = 6'($countones(e.mask));
        if (cur_st == L) begin
            m_wc  = m_wc + 48'd1;
            m_bec = m_bec + 48'(e.bits);
            m_wec = m_wec + 32'(e.mask != 0);
            if (st == H) m_llc = m_llc + 16'd1;
        end
        if (clr) begin
            m_wc = '0; m_bec = '0; m_wec = '0; m_llc = '0;
        end
        e.st = st; e.wc = m_wc; e.bec = m_bec; e.wec = m_wec; e.llc = m_llc;
        cur_st = st;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(e);
    endtask
    task automatic do_reset();
        exp_t e;
        reset = 1'b1;
        bus.data_in = 32'hFFFF_FFFF;
        bus.clear = 1'b1;
        m_wc = '0; m_bec = '0; m_wec = '0; m_llc = '0;
        cur_st = H;
        e = '{mask: 32'h0, bits: 6'h0, st: H, wc: 48'h0, bec: 48'h0, wec: 32'h0, llc: 16'h0};
        @(posedge clk);
        #1;
        check_outputs(e);
        reset = 1'b0;
        bus.clear = 1'b0;
    endtask
    // First word only loads prev; 64 matches follow, the last of which enters LOCKED.
    task automatic relock();
        for (int k = 0; k <= 64; k++) send(32'h0, 1'b0, 1'b0, k == 0 ? H : k < 64 ? V : L);
    endtask
    initial begin
        bus.data_in = '0;
        bus.clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 500; i++) send(32'h0, 1'b1, 1'b0, H);
        relock();
        for (int i = 0; i < 20; i++) send(32'h0, 1'b0, 1'b0, L);
        send(32'h0002_0001, 1'b0, 1'b0, L);
        for (int i = 0; i < 14; i++) begin
            send(32'h0, 1'b0, 1'b0, L);
            send(32'h1 << i, 1'b0, 1'b0, L);
        end
        send(32'h0, 1'b0, 1'b0, L);
        send(32'h0010_0000, 1'b0, 1'b0, H);
        relock();
        for (int i = 0; i < 3; i++) send(32'h0, 1'b0, 1'b0, L);
        send(32'h0000_0020, 1'b0, 1'b1, L);
        send(32'h0, 1'b0, 1'b0, L);
        send(32'h8000_0003, 1'b0, 1'b0, L);
        send(32'h0, 1'b0, 1'b0, L);
        do_reset();
        relock();
        for (int i = 0; i < 5; i++) send(32'h0, 1'b0, 1'b0, L);
        send(32'h0000_0100, 1'b0, 1'b0, L);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
